// File: rtl/f1_pkg.sv
// Shared definitions for the reaction timer and the CPU top that feeds it.
//   rt_state_t    : reaction timer FSM state encoding
//   LIGHTS_W_DEF  : default number of start lights
//   COUNT_W_DEF   : default width of the reaction-time counter/result
package f1_pkg;

  localparam int LIGHTS_W_DEF = 8;
  localparam int COUNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    FALSE_START
  } rt_state_t;

endpackage

// File: rtl/reaction_timer_if.sv
// Bundle between the CPU side (master) and the reaction timer (slave).
//   a0           : CPU register a0, low LIGHTS_W bits are the light pattern
//   btn          : asynchronous driver button, active-high
//   lights       : registered light pattern
//   result       : last captured reaction time in ticks
//   result_valid : high while a result is being presented
//   false_start  : high while a false start is being flagged
//   best_time    : lowest result so far (all-ones when not tracked)
interface reaction_timer_if #(
  parameter int LIGHTS_W = 8,
  parameter int COUNT_W  = 16
);

  logic [31:0]         a0;
  logic                btn;
  logic [LIGHTS_W-1:0] lights;
  logic [COUNT_W-1:0]  result;
  logic                result_valid;
  logic                false_start;
  logic [COUNT_W-1:0]  best_time;

  modport master (
    output a0, btn,
    input  lights, result, result_valid, false_start, best_time
  );

  modport slave (
    input  a0, btn,
    output lights, result, result_valid, false_start, best_time
  );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   async_in : asynchronous level input
//   pulse    : one-cycle pulse, three cycles after async_in rises
// A held input yields exactly one pulse.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// F1 start-light reaction timer. Registers the light pattern from a0, arms
// when all lights are on, starts timing at lights-out and captures the tick
// count at the next button press. A press while armed is a false start.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : reaction_timer_if slave (a0, btn in; lights, result,
//         result_valid, false_start, best_time out)
// Optional feature macro: REACTION_BEST_EN keeps a best (lowest) result
// register; without it best_time is tied to all-ones.
//
// state       | meaning
// IDLE        | waiting for all lights on
// ARMED       | all lights on, waiting for lights out
// TIMING      | lights out, counting ticks until press
// DONE        | result captured and presented
// FALSE_START | press seen while armed
module reaction_timer
  import f1_pkg::*;
#(
  parameter int LIGHTS_W     = LIGHTS_W_DEF,
  parameter int CLK_PER_TICK = 1000,
  parameter int COUNT_W      = COUNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  reaction_timer_if.slave bus
);

  localparam int                 PRE_W     = $clog2(CLK_PER_TICK);
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  rt_state_t           state;
  logic [LIGHTS_W-1:0] lights_q;
  logic [PRE_W-1:0]    presc;
  logic [COUNT_W-1:0]  count;
  logic [COUNT_W-1:0]  result_q;
  logic                result_valid_q;
  logic                false_start_q;
  logic                press;
  logic                all_on;
  logic                all_off;
  logic                mid;
  logic                unused_a0_hi;

  assign unused_a0_hi = ^bus.a0[31:LIGHTS_W];

  btn_sync u_btn_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.btn),
    .pulse    (press)
  );

  always_ff @(posedge clk) begin
    if (rst) lights_q <= '0;
    else     lights_q <= bus.a0[LIGHTS_W-1:0];
  end

  assign all_on  = &lights_q;
  assign all_off = ~|lights_q;
  assign mid     = !all_on && !all_off;

  // result_valid/false_start are updated on the transitions into and out of
  // DONE/FALSE_START, so they track the registered state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      presc          <= '0;
      count          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (all_on) state <= ARMED;
        end
        ARMED: begin
          if (press) begin
            state         <= FALSE_START;
            false_start_q <= 1'b1;
          end else if (all_off) begin
            state <= TIMING;
            presc <= '0;
            count <= '0;
          end else if (mid) begin
            state <= IDLE;
          end
        end
        TIMING: begin
          if (press) begin
            // capture the count as it stood entering this cycle; a tick
            // landing on the same cycle is deliberately not included
            state          <= DONE;
            result_q       <= count;
            result_valid_q <= 1'b1;
          end else if (presc == PRE_LAST) begin
            presc <= '0;
            if (count != COUNT_MAX) count <= count + 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        DONE: begin
          if (mid) begin
            state          <= IDLE;
            result_valid_q <= 1'b0;
          end
        end
        FALSE_START: begin
          if (mid) begin
            state         <= IDLE;
            false_start_q <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          result_valid_q <= 1'b0;
          false_start_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REACTION_BEST_EN
  logic [COUNT_W-1:0] best_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= '1;
    end else if (state == TIMING && press && count < best_q) begin
      best_q <= count;
    end
  end

  assign bus.best_time = best_q;
`else
  assign bus.best_time = '1;
`endif

  assign bus.lights       = lights_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.false_start  = false_start_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer (CLK_PER_TICK=4, COUNT_W=8, LIGHTS_W=8).
// Stimulus pushes the expected event; a monitor pops and compares whenever
// result_valid or false_start rises.
module tb_reaction_timer;

  logic clk;
  logic rst;

  reaction_timer_if #(.LIGHTS_W(8), .COUNT_W(8)) bus ();

  reaction_timer #(
    .LIGHTS_W     (8),
    .CLK_PER_TICK (4),
    .COUNT_W      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef REACTION_BEST_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  typedef struct {
    bit         is_fs;
    logic [7:0] result;
    logic [7:0] best;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] best_of(input logic [7:0] v);
    return BEST_EN ? v : 8'hFF;
  endfunction

  task automatic push(input bit is_fs, input logic [7:0] res, input logic [7:0] best);
    exp_t e;
    e.is_fs  = is_fs;
    e.result = res;
    e.best   = best_of(best);
    exp_q.push_back(e);
  endtask

  // full sequence: mid -> all on -> lights out, press w cycles after lights==0
  task automatic run(input int w, input logic [7:0] res, input logic [7:0] best);
    bus.a0 = 32'h01; cyc(3);
    bus.a0 = 32'hFF; cyc(3);
    bus.a0 = 32'h00; cyc(1 + w);
    push(1'b0, res, best);
    bus.btn = 1'b1; cyc(8);
    bus.btn = 1'b0; cyc(3);
    bus.a0 = 32'h01; cyc(3);
    chk("result_retained", bus.result, res);
    chk("valid_cleared", bus.result_valid, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_lights"}, bus.lights, 8'h00);
    chk({tag, "_result"}, bus.result, 8'h00);
    chk({tag, "_valid"}, bus.result_valid, 1'b0);
    chk({tag, "_fs"}, bus.false_start, 1'b0);
    chk({tag, "_best"}, bus.best_time, 8'hFF);
  endtask

  // monitor
  initial begin
    logic prev_rv;
    logic prev_fs;
    exp_t e;
    prev_rv = 1'b0;
    prev_fs = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.result_valid && !prev_rv) || (bus.false_start && !prev_fs)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {bus.result_valid, bus.false_start}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("ev_valid", bus.result_valid, !e.is_fs);
          chk("ev_fs", bus.false_start, e.is_fs);
          chk("ev_result", bus.result, e.result);
          chk("ev_best", bus.best_time, e.best);
        end
      end
      prev_rv = bus.result_valid;
      prev_fs = bus.false_start;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.a0 = 32'h0;
    bus.btn = 1'b0;
    cyc(3);
    chk_reset("por");
    rst = 1'b0;
    cyc(2);

    // lights step up one by one, then out; press 40 cycles after lights==0
    bus.a0 = 32'h01; cyc(2);
    for (int i = 1; i < 8; i++) begin
      bus.a0 = (32'h1 << (i + 1)) - 1; cyc(2);
    end
    bus.a0 = 32'h00; cyc(41);
    push(1'b0, 8'd10, 8'd10);
    bus.btn = 1'b1; cyc(8);
    chk("run1_fs_low", bus.false_start, 1'b0);
    bus.btn = 1'b0; cyc(3);

    // false start: press while all lights on
    bus.a0 = 32'h01; cyc(3);
    bus.a0 = 32'hFF; cyc(3);
    push(1'b1, 8'd10, 8'd10);
    bus.btn = 1'b1; cyc(8);
    chk("fs_held", bus.false_start, 1'b1);
    bus.btn = 1'b0; cyc(2);
    bus.a0 = 32'h01; cyc(3);
    chk("fs_cleared", bus.false_start, 1'b0);
    chk("fs_result_kept", bus.result, 8'd10);

    // saturation: (1100+2)/4 = 275 -> 255
    run(1100, 8'd255, 8'd10);
    // press on prescaler wrap: count 5, tick not included
    run(21, 8'd5, 8'd5);

    // reset during TIMING
    bus.a0 = 32'h01; cyc(3);
    bus.a0 = 32'hFF; cyc(3);
    bus.a0 = 32'h00; cyc(20);
    rst = 1'b1; cyc(1);
    chk_reset("mid_rst");
    rst = 1'b0; cyc(2);
    bus.btn = 1'b1; cyc(10);
    bus.btn = 1'b0;
    chk("post_rst_valid", bus.result_valid, 1'b0);
    chk("post_rst_fs", bus.false_start, 1'b0);
    chk("post_rst_result", bus.result, 8'd0);
    cyc(3);

    // best-time tracking: 20, 12, 30
    run(78, 8'd20, 8'd20);
    run(46, 8'd12, 8'd12);
    run(118, 8'd30, 8'd12);

    cyc(10);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
